addcp_framer: RTL and testbench

Parametrised successor to the fixed 256/64 cyclic-prefix inserter. It takes a frame of OFDM time-domain symbols, buffers each symbol in an internal ping-pong RAM, and emits a framed stream: head sync sequence, then for each symbol its CP followed by the full symbol, then tail sync sequence. Runs on one clock, with valid/ready backpressure on both sides. It sits between the IFFT output and the DAC/LED driver.

---
 rtl/addcp_pkg.sv | 27 ++
 rtl/addcp_pingpong_ram.sv | 32 +++
 rtl/addcp_framer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_addcp_framer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/addcp_pkg.sv
// Shared types and helpers for the cyclic-prefix framer and its ping-pong RAM.
// Optional underrun counter is enabled by defining ADDCP_UNDERRUN_CNT_EN.
package addcp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_WAIT,
        ST_CP,
        ST_BODY,
        ST_TAIL
    } rd_state_t;

    // Source of a read in flight: symbol RAM or the external sync ROM.
    localparam logic SRC_RAM  = 1'b0;
    localparam logic SRC_SYNC = 1'b1;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int frame_len(input int n_fft, input int cp_len,
                                     input int sync_len, input int nsyms);
        return 2 * sync_len + nsyms * (n_fft + cp_len);
    endfunction

endpackage

// File: rtl/addcp_pingpong_ram.sv
// Two N_FFT-deep symbol banks with one write and one registered read port.
// Full/empty bookkeeping lives in the framer.
module addcp_pingpong_ram #(
    parameter int DATA_W = 8,
    parameter int N_FFT  = 256,
    parameter int AW     = 8
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] bank0 [N_FFT];
    logic [DATA_W-1:0] bank1 [N_FFT];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            if (wr_bank) bank1[wr_addr] <= wr_data;
            else         bank0[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

endmodule

// File: rtl/addcp_framer.sv
// OFDM framer: head sync, then CP + symbol per buffered symbol, then tail sync.
// Define ADDCP_UNDERRUN_CNT_EN to add the saturating WAIT-cycle counter output.
module addcp_framer
    import addcp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int N_FFT    = 256,
    parameter int CP_LEN   = 64,
    parameter int SYNC_LEN = 12,
    parameter int SYMS_W   = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic [SYMS_W-1:0]           nsyms,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [addr_w(SYNC_LEN)-1:0] sync_addr,
    input  logic [DATA_W-1:0]           sync_data,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
`ifdef ADDCP_UNDERRUN_CNT_EN
    output logic [15:0]                 underrun_cnt,
`endif
    output logic                        busy
);

    localparam int AW = addr_w(N_FFT);
    localparam int SW = addr_w(SYNC_LEN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_FFT - 1);
    localparam logic [AW-1:0] CP_START  = AW'(N_FFT - CP_LEN);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);

    rd_state_t         state, state_n;
    logic [SYMS_W-1:0] nsyms_q, wr_cnt, rd_cnt, rd_cnt_n;
    logic [AW-1:0]     wr_addr, rd_addr, rd_addr_n;
    logic [SW-1:0]     sync_cnt, sync_cnt_n;
    logic              wr_bank, rd_bank, rd_bank_n;
    logic [1:0]        bank_full, bank_full_n;
    logic              start_acc, wr_fire, wr_done, pop, can_issue;
    logic              rd_issue, rd_src, rd_last, free_bank;
    logic              vld_p0, src_p0, last_p0;
    logic [DATA_W-1:0] ram_q, data_p0;
    logic [1:0]        occ;
    logic [DATA_W-1:0] sk_data0, sk_data1;
    logic              sk_last0, sk_last1;

    assign start_acc = frame_start & ~busy;
    assign in_ready  = busy & ~bank_full[wr_bank] & (wr_cnt != nsyms_q);
    assign wr_fire   = in_valid & in_ready;
    assign wr_done   = wr_fire & (wr_addr == LAST_ADDR);
    assign out_valid = (occ != 2'd0);
    assign out_data  = sk_data0;
    assign out_last  = sk_last0 & out_valid;
    assign pop       = out_valid & out_ready;
    assign sync_addr = sync_cnt;
    // Slots left in the skid buffer, counting the read already in flight.
    assign can_issue = (occ + {1'b0, vld_p0} - {1'b0, pop}) < 2'd2;

    addcp_pingpong_ram #(.DATA_W(DATA_W), .N_FFT(N_FFT), .AW(AW)) u_ram (
        .clock   (clock),
        .wr_en   (wr_fire),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_en   (rd_issue & (rd_src == SRC_RAM)),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_comb begin
        state_n    = state;
        sync_cnt_n = sync_cnt;
        rd_addr_n  = rd_addr;
        rd_cnt_n   = rd_cnt;
        rd_bank_n  = rd_bank;
        rd_issue   = 1'b0;
        rd_src     = SRC_RAM;
        rd_last    = 1'b0;
        free_bank  = 1'b0;
        case (state)
            ST_IDLE: if (start_acc) begin
                state_n    = ST_HEAD;
                sync_cnt_n = '0;
                rd_cnt_n   = '0;
            end
            ST_HEAD: if (can_issue) begin
                rd_issue = 1'b1;
                rd_src   = SRC_SYNC;
                if (sync_cnt == SYNC_LAST) begin
                    sync_cnt_n = '0;
                    state_n    = (nsyms_q != '0) ? ST_WAIT : ST_TAIL;
                end else begin
                    sync_cnt_n = sync_cnt + 1'b1;
                end
            end
            ST_WAIT: if (bank_full[rd_bank]) begin
                state_n   = ST_CP;
                rd_addr_n = CP_START;
            end
            ST_CP: if (can_issue) begin
                rd_issue = 1'b1;
                if (rd_addr == LAST_ADDR) begin
                    rd_addr_n = '0;
                    state_n   = ST_BODY;
                end else begin
                    rd_addr_n = rd_addr + 1'b1;
                end
            end
            ST_BODY: if (can_issue) begin
                rd_issue = 1'b1;
                if (rd_addr == LAST_ADDR) begin
                    rd_addr_n = '0;
                    free_bank = 1'b1;
                    rd_bank_n = ~rd_bank;
                    rd_cnt_n  = rd_cnt + 1'b1;
                    if (rd_cnt_n == nsyms_q) begin
                        state_n = ST_TAIL;
                    end else if (bank_full[~rd_bank]) begin
                        state_n   = ST_CP;
                        rd_addr_n = CP_START;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end else begin
                    rd_addr_n = rd_addr + 1'b1;
                end
            end
            ST_TAIL: if (can_issue) begin
                rd_issue = 1'b1;
                rd_src   = SRC_SYNC;
                if (sync_cnt == SYNC_LAST) begin
                    rd_last    = 1'b1;
                    sync_cnt_n = '0;
                    state_n    = ST_IDLE;
                end else begin
                    sync_cnt_n = sync_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // A bank filling in the same cycle the other is freed keeps its full flag.
    always_comb begin
        bank_full_n = bank_full;
        if (free_bank) bank_full_n[rd_bank] = 1'b0;
        if (wr_done)   bank_full_n[wr_bank] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            nsyms_q   <= '0;
            sync_cnt  <= '0;
            rd_addr   <= '0;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            wr_addr   <= '0;
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            bank_full <= 2'b00;
        end else begin
            state     <= state_n;
            sync_cnt  <= sync_cnt_n;
            rd_addr   <= rd_addr_n;
            rd_cnt    <= rd_cnt_n;
            rd_bank   <= rd_bank_n;
            bank_full <= bank_full_n;
            if (start_acc) begin
                busy    <= 1'b1;
                nsyms_q <= nsyms;
                wr_addr <= '0;
                wr_cnt  <= '0;
            end else begin
                if (pop && sk_last0) busy <= 1'b0;
                if (wr_fire) begin
                    if (wr_done) begin
                        wr_addr <= '0;
                        wr_cnt  <= wr_cnt + 1'b1;
                        wr_bank <= ~wr_bank;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
            end
        end
    end

    // ---- stage p0: RAM / ROM read data returns ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            src_p0  <= SRC_RAM;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= rd_issue;
            src_p0  <= rd_src;
            last_p0 <= rd_last;
        end
    end

    assign data_p0 = (src_p0 == SRC_SYNC) ? sync_data : ram_q;

    // ---- skid buffer: entry 0 drives the output and only moves on a pop ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ      <= 2'd0;
            sk_data0 <= '0;
            sk_data1 <= '0;
            sk_last0 <= 1'b0;
            sk_last1 <= 1'b0;
        end else begin
            case ({vld_p0, pop})
                2'b11: begin
                    if (occ == 2'd1) begin
                        sk_data0 <= data_p0;
                        sk_last0 <= last_p0;
                    end else begin
                        sk_data0 <= sk_data1;
                        sk_last0 <= sk_last1;
                        sk_data1 <= data_p0;
                        sk_last1 <= last_p0;
                    end
                end
                2'b01: begin
                    sk_data0 <= sk_data1;
                    sk_last0 <= sk_last1;
                    occ      <= occ - 1'b1;
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        sk_data0 <= data_p0;
                        sk_last0 <= last_p0;
                    end else begin
                        sk_data1 <= data_p0;
                        sk_last1 <= last_p0;
                    end
                    occ <= occ + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ADDCP_UNDERRUN_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (start_acc) begin
            underrun_cnt <= '0;
        end else if (state == ST_WAIT && busy && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_addcp_framer.sv
// Directed bench for addcp_framer at N_FFT=16, CP_LEN=4, SYNC_LEN=4, ROM = 0xA0+addr.
module tb_addcp_framer;
    import addcp_pkg::*;

    localparam int NF = 16;
    localparam int CP = 4;
    localparam int SL = 4;

    logic       clock, reset, frame_start, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [7:0] nsyms, in_data, sync_data, out_data;
    logic [1:0] sync_addr;
`ifdef ADDCP_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    addcp_framer #(.DATA_W(8), .N_FFT(NF), .CP_LEN(CP), .SYNC_LEN(SL), .SYMS_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .nsyms       (nsyms),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sync_addr   (sync_addr),
        .sync_data   (sync_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
`ifdef ADDCP_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock) sync_data <= 8'hA0 + {6'b0, sync_addr};

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] got_q[$];
    bit         last_q[$];
    int         gaps, first_valid;
    bit         in_rdy_seen, done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int ns, input bit rnd_ready, input int stall_at,
                             input int stall_len, input bit spam, input int abort_at,
                             input string name);
        int         in_idx = 0;
        int         stall_cnt = 0;
        int         total = frame_len(NF, CP, SL, ns);
        bit         prev_stall = 0;
        logic [7:0] held_d = 8'h00;
        logic       held_l = 1'b0;
        got_q.delete();
        last_q.delete();
        gaps = 0;
        first_valid = -1;
        in_rdy_seen = 0;
        done = 0;
        @(negedge clock);
        nsyms = 8'(ns);
        frame_start = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clock);
            frame_start = 1'b0;
            if (abort_at >= 0 && got_q.size() >= abort_at) begin
                reset = 1'b1;
                #1;
                check({name, " abort out_valid"}, 32'(out_valid), 0);
                check({name, " abort in_ready"}, 32'(in_ready), 0);
                check({name, " abort busy"}, 32'(busy), 0);
                check({name, " abort out_last"}, 32'(out_last), 0);
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (spam && busy) begin
                frame_start = 1'b1;
                nsyms = 8'd5;
            end
            in_valid = 1'b0;
            if (in_idx < ns * NF) begin
                if (in_idx == stall_at && stall_cnt < stall_len) stall_cnt++;
                else begin
                    in_valid = 1'b1;
                    in_data = 8'(in_idx);
                end
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_ready) in_rdy_seen = 1;
            if (in_valid && in_ready) in_idx++;
            if (prev_stall) begin
                check({name, " hold valid"}, 32'(out_valid), 1);
                check({name, " hold data"}, 32'(out_data), 32'(held_d));
                check({name, " hold last"}, 32'(out_last), 32'(held_l));
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (!out_valid && got_q.size() >= 24 && got_q.size() < total) gaps++;
            prev_stall = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_q.push_back(out_last);
                if (out_last) done = 1;
            end
        end
        check({name, " frame completed"}, 32'(done), 1);
        @(negedge clock);
        frame_start = 1'b0;
        in_valid = 1'b0;
        #1;
        check({name, " busy after last"}, 32'(busy), 0);
        check({name, " idle out_valid"}, 32'(out_valid), 0);
    endtask

    task automatic check_seq(input int ns, input string name);
        logic [7:0] exp_q[$];
        int         total = frame_len(NF, CP, SL, ns);
        for (int i = 0; i < SL; i++) exp_q.push_back(8'(8'hA0 + i));
        for (int s = 0; s < ns; s++) begin
            for (int k = NF - CP; k < NF; k++) exp_q.push_back(8'(s * NF + k));
            for (int k = 0; k < NF; k++) exp_q.push_back(8'(s * NF + k));
        end
        for (int i = 0; i < SL; i++) exp_q.push_back(8'(8'hA0 + i));
        check({name, " length"}, 32'(got_q.size()), 32'(total));
        for (int i = 0; i < total && i < got_q.size(); i++) begin
            check($sformatf("%s sample %0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
            check($sformatf("%s last %0d", name, i), 32'(last_q[i]), 32'(i == total - 1));
        end
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        nsyms = 8'd0;
        in_data = 8'd0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset in_ready", 32'(in_ready), 0);
        check("reset busy", 32'(busy), 0);
        check("reset out_last", 32'(out_last), 0);
        check("reset out_data", 32'(out_data), 0);
        check("reset sync_addr", 32'(sync_addr), 0);
        @(negedge clock);
        reset = 1'b0;

        run_frame(1, 0, -1, 0, 0, -1, "s1");
        check_seq(1, "s1");
        check("s1 first out_valid latency", 32'(first_valid), 2);

        run_frame(0, 0, -1, 0, 0, -1, "s2");
        check_seq(0, "s2");
        check("s2 in_ready never", 32'(in_rdy_seen), 0);

        run_frame(3, 0, -1, 0, 0, -1, "s3");
        check_seq(3, "s3");
        check("s3 no gap after symbol 1", 32'(gaps), 0);

        run_frame(3, 1, -1, 0, 1, -1, "s4");
        check_seq(3, "s4");

        run_frame(3, 0, NF + 8, 10, 0, -1, "s5");
        check_seq(3, "s5");
        check("s5 wait gap seen", 32'(gaps > 0), 1);
`ifdef ADDCP_UNDERRUN_CNT_EN
        check("s5 underrun >= 10", 32'(underrun_cnt >= 16'd10), 1);
`endif

        run_frame(3, 0, -1, 0, 0, 33, "s6");
        run_frame(1, 0, -1, 0, 0, -1, "s6b");
        check_seq(1, "s6b");
        check("s6b first out_valid latency", 32'(first_valid), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
